// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared legal-range constants and sizing helper for the handshake multiplier
package mult_pkg;

    localparam int WIDTH_MIN  = 2;
    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    // Width able to count 0..STAGES+1 held entries
    function automatic int occ_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/mult_core.sv
// rtl/mult_core.sv - combinational multiplier on (WIDTH+1)-bit extended operands
module mult_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]       a,
    input  logic [WIDTH:0]       b,
    output logic [2*WIDTH-1:0]   p
);

    logic [2*WIDTH-1:0] a_x;
    logic [2*WIDTH-1:0] b_x;

    // Top bit of each operand carries the sign (or zero), so widening by it
    // makes the 2*WIDTH-bit truncated product exact in both modes.
    assign a_x = {{(WIDTH-1){a[WIDTH]}}, a};
    assign b_x = {{(WIDTH-1){b[WIDTH]}}, b};
    assign p   = a_x * b_x;

endmodule

// File: rtl/mult_pipe_hs.sv
// rtl/mult_pipe_hs.sv - valid/ready pipelined multiplier with bubble collapse and tag sideband
module mult_pipe_hs
    import mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_signed,
    input  logic [WIDTH-1:0]              multiplicand,
    input  logic [WIDTH-1:0]              multiplier,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WIDTH-1:0]            product,
    output logic [TAG_W-1:0]              out_tag,
    output logic [occ_width(STAGES)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(STAGES);
    localparam int PW    = 2 * WIDTH;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mult_pipe_hs: WIDTH out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("mult_pipe_hs: STAGES out of range");
    end

    logic [STAGES:0]    vld;
    logic [STAGES:0]    load;

    logic               s0_signed;
    logic [WIDTH-1:0]   s0_a;
    logic [WIDTH-1:0]   s0_b;
    logic [TAG_W-1:0]   s0_tag;

    logic [PW-1:0]      pdata [1:STAGES];
    logic [TAG_W-1:0]   ptag  [1:STAGES];
    logic [PW-1:0]      core_p;

    // A slot may load when it is empty or its own contents move on this cycle
    always_comb begin
        load = '0;
        load[STAGES] = !vld[STAGES] || out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load[i] = !vld[i] || load[i+1];
        end
    end

    assign in_ready = load[0];

    mult_core #(.WIDTH(WIDTH)) u_core (
        .a ({s0_signed & s0_a[WIDTH-1], s0_a}),
        .b ({s0_signed & s0_b[WIDTH-1], s0_b}),
        .p (core_p)
    );

    // Data registers only move when real data arrives, so an empty output
    // slot never disturbs product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            s0_signed <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            s0_tag    <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                pdata[i] <= '0;
                ptag[i]  <= '0;
            end
        end else begin
            if (load[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    s0_signed <= in_signed;
                    s0_a      <= multiplicand;
                    s0_b      <= multiplier;
                    s0_tag    <= in_tag;
                end
            end
            if (load[1]) begin
                vld[1] <= vld[0];
                if (vld[0]) begin
                    pdata[1] <= core_p;
                    ptag[1]  <= s0_tag;
                end
            end
            for (int i = 2; i <= STAGES; i++) begin
                if (load[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        pdata[i] <= pdata[i-1];
                        ptag[i]  <= ptag[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign product   = pdata[STAGES];
    assign out_tag   = ptag[STAGES];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i <= STAGES; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

endmodule

// File: tb/tb_mult_pipe_hs.sv
// tb/tb_mult_pipe_hs.sv - scoreboard bench for mult_pipe_hs at WIDTH=32, STAGES=2
module tb_mult_pipe_hs;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 4;
    localparam int OW = $clog2(S + 2);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_signed;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   out_tag;
    logic [OW-1:0]   occupancy;
    logic [2*W-1:0]  drv_exp;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_acc    = 0;
    int              n_ret    = 0;
    bit              prev_stall = 1'b0;
    logic [2*W-1:0]  prev_p;
    logic [TW-1:0]   prev_t;
    int              a0;
    int              r0;

    always #5 clk = ~clk;

    mult_pipe_hs #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .out_tag      (out_tag),
        .occupancy    (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 64'(x * y);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Handshakes are decided at the negedge, where inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_hold_product", product, prev_p);
                check("stall_hold_tag", 64'(out_tag), 64'(prev_t));
            end
            if (in_valid && in_ready) begin
                sb.push_back('{p: drv_exp, t: in_tag});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_ret++;
                if (sb.size() == 0) begin
                    check("retire_with_empty_scoreboard", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("product", product, e.p);
                    check("out_tag", 64'(out_tag), 64'(e.t));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = product;
            prev_t     = out_tag;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] t, input logic [63:0] x);
        multiplicand = a;
        multiplier   = b;
        in_signed    = s;
        in_tag       = t;
        drv_exp      = x;
        in_valid     = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] t, input logic [63:0] x);
        bit ok;
        ok = 1'b0;
        drive(a, b, s, t, x);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("send_accept_timeout", 64'(0), 64'(1));
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0;
        multiplicand = '0; multiplier = '0; in_tag = '0; drv_exp = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_product", product, 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        check("in_ready_after_reset", 64'(in_ready), 64'(1));

        // Latency: accepted at edge 0, visible after edge 2
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001);
        check("lat_edge0_valid", 64'(out_valid), 64'(0));
        step();
        check("lat_edge1_valid", 64'(out_valid), 64'(0));
        step();
        check("lat_edge2_valid", 64'(out_valid), 64'(1));
        check("lat_edge2_product", product, 64'hFFFF_FFFE_0000_0001);
        check("lat_edge2_tag", 64'(out_tag), 64'(3));

        send(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd6, 64'h4000_0000_0000_0000);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd7, 64'hC000_0000_8000_0000);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd8, 64'h4000_0000_0000_0000);
        repeat (5) step();
        check("directed_drain_occ", 64'(occupancy), 64'(0));

        // Backpressure: six offered, three held
        out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive(32'(i + 1), 32'(i + 10), 1'b0, 4'(i), ref_mul(32'(i + 1), 32'(i + 10), 1'b0));
            step();
        end
        check("bp_accepts", 64'(n_acc - a0), 64'(3));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_occupancy", 64'(occupancy), 64'(3));

        // Full block: accept and retire on the same edge
        drive(32'd1000, 32'd3, 1'b0, 4'd9, 64'd3000);
        out_ready = 1'b1;
        a0 = n_acc;
        r0 = n_ret;
        #1;
        check("full_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_accepts", 64'(n_acc - a0), 64'(1));
        check("full_retires", 64'(n_ret - r0), 64'(1));
        check("full_occupancy", 64'(occupancy), 64'(3));
        out_ready = 1'b1;
        repeat (5) step();
        check("bp_drain_retires", 64'(n_ret - r0), 64'(4));
        check("bp_drain_in_ready", 64'(in_ready), 64'(1));
        check("bp_drain_occ", 64'(occupancy), 64'(0));

        // Random traffic
        a0 = n_acc;
        for (int cyc = 0; cyc < 40000 && (n_acc - a0) < 10000; cyc++) begin
            if ($urandom_range(3) != 0) begin
                ra = pick();
                rb = pick();
                rs = 1'($urandom_range(1));
                drive(ra, rb, rs, 4'($urandom), ref_mul(ra, rb, rs));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        in_valid  = 1'b0;
        check("rand_accepts", 64'(n_acc - a0), 64'(10000));
        out_ready = 1'b1;
        repeat (6) step();
        check("rand_drain_sb", 64'(sb.size()), 64'(0));
        check("rand_drain_occ", 64'(occupancy), 64'(0));

        // Reset with three operations in flight
        out_ready = 1'b0;
        send(32'd7, 32'd9, 1'b0, 4'd1, 64'd63);
        send(32'd8, 32'd9, 1'b0, 4'd2, 64'd72);
        send(32'd9, 32'd9, 1'b0, 4'd3, 64'd81);
        check("pre_rst_occ", 64'(occupancy), 64'(3));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_occ", 64'(occupancy), 64'(0));
        check("mid_rst_product", product, 64'(0));
        sb.delete();
        r0 = n_ret;
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) step();
        check("post_rst_no_retire", 64'(n_ret - r0), 64'(0));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("end_sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_pipe_hs.md
MULT_PIPE_HS -- requirements
Module: mult_pipe_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline register stages after the input register, legal range 1..8.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation, minimum 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  an operation is offered on this cycle.
REQ-007 in_ready  output  1  the block can accept an operation on this cycle.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 multiplicand  input  WIDTH  operand A.
REQ-010 multiplier  input  WIDTH  operand B.
REQ-011 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-012 out_valid  output  1  a result is presented on this cycle.
REQ-013 out_ready  input  1  the consumer accepts the result on this cycle.
REQ-014 product  output  2*WIDTH  result; registered output.
REQ-015 out_tag  output  TAG_W  tag of the presented result.
REQ-016 occupancy  output  $clog2(STAGES+2)  number of valid entries held in the block.

Function
REQ-017 An operation SHALL be accepted on a rising edge only when in_valid and in_ready are both 1.
REQ-018 A result SHALL be retired on a rising edge only when out_valid and out_ready are both 1.
REQ-019 Unsigned mode SHALL produce product = A*B, exact in 2*WIDTH bits.
REQ-020 Signed mode SHALL produce the exact two's-complement product in 2*WIDTH bits, including (-2^(WIDTH-1))^2.
REQ-021 The block SHALL hold STAGES+1 register slots (input register plus STAGES), each with its own valid bit; the last slot drives product, out_tag and out_valid.
REQ-022 A slot SHALL load from its predecessor when the slot is empty or is itself advancing this cycle (bubble collapse); otherwise it holds its value.
REQ-023 in_ready SHALL be 1 when the input slot is empty or is advancing this cycle; it SHALL be combinational only from internal valids and out_ready.
REQ-024 An operation accepted at edge N SHALL be presented with out_valid=1 after edge N+STAGES when no stall occurs, and SHALL sustain a throughput of 1 per cycle.
REQ-025 Under backpressure, at most STAGES+1 operations SHALL be held; results SHALL retire in acceptance order, with no loss and no duplication.
REQ-026 While out_valid=1 and out_ready=0, product and out_tag SHALL remain stable.
REQ-027 occupancy SHALL equal the count of set valid bits and SHALL update on the same edges as those bits.
REQ-028 Simultaneous accept and retire with the block full SHALL be permitted and SHALL leave occupancy unchanged.
REQ-029 Data registers in empty slots SHALL NOT change product while out_valid=0, except on reset.

Reset
REQ-030 rst_n=0 SHALL immediately clear all valid bits, product, out_tag and occupancy to 0, regardless of the clock.
REQ-031 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear at the output after reset.

Structure
REQ-033 Shared package mult_pkg SHALL hold the WIDTH and STAGES legal-range constants and the occupancy-width helper function.
REQ-034 Multiplication SHALL be done in sub-module mult_core, a combinational unsigned (WIDTH+1)x(WIDTH+1) multiplier fed by sign- or zero-extended operands from the input slot.
REQ-035 mult_core's product SHALL be taken in 2*WIDTH bits and registered into slot 1; pipeline registers SHALL be placed for retiming.

Verification (WIDTH=32, STAGES=2)
REQ-036 Unsigned: accept 0xFFFFFFFF*0xFFFFFFFF with tag 3 at edge 0 -> out_valid after edge 2, product=0xFFFFFFFE00000001, out_tag=3.
REQ-037 Signed: 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFFFFFFFFFE; 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-038 Hold out_ready=0, in_valid=1 for 6 cycles -> exactly 3 accepts, then in_ready=0, occupancy=3; release -> 3 results in order, then in_ready=1.
REQ-039 Random streams with random in_valid/out_ready over 10k operations -> every result matches a reference model, in order, with tags intact; at most 1 retire per cycle.
REQ-040 Pull rst_n low with 3 operations in flight -> out_valid=0 and occupancy=0 immediately; no stale result after release.
REQ-041 Full block with in_valid=1 and out_ready=1 on the same cycle -> one accept and one retire, occupancy stays 3.
